// File: rtl/di_reg_master_pkg.sv
// Shared definitions for the DI-bus register initiator: FSM state encoding,
// response codes and DI address/data widths.
package di_reg_master_pkg;

  localparam int DI_TERM_W   = 16;
  localparam int DI_ADDR_W   = 32;
  localparam int DI_DATA_W   = 32;
  localparam int DI_STATUS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WWAIT = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RESP  = 3'd5
  } di_state_t;

  localparam logic [1:0] DI_RSP_OK       = 2'd0;
  localparam logic [1:0] DI_RSP_XFER_ERR = 2'd1;
  localparam logic [1:0] DI_RSP_TIMEOUT  = 2'd2;
  localparam logic [1:0] DI_RSP_NO_TERM  = 2'd3;

endpackage

// File: rtl/di_timeout_cnt.sv
// Wait-state counter: cleared while not waiting, counts stalled cycles and
// flags the last cycle the initiator is allowed to wait.
module di_timeout_cnt #(
  parameter int TO_WIDTH       = 11,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_WIDTH-1:0] TC_VALUE = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] count;

  // Count stalled cycles; clear has priority so each wait starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/di_reg_master.sv
// Single-outstanding DI-bus initiator: converts a command/response request
// into the DI terminal read/write handshake and reports data and status.
module di_reg_master
  import di_reg_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic                   di_clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [DI_TERM_W-1:0]   cmd_term,
  input  logic [DI_ADDR_W-1:0]   cmd_addr,
  input  logic [DI_DATA_W-1:0]   cmd_wdata,
  output logic                   rsp_valid,
  output logic [DI_DATA_W-1:0]   rsp_rdata,
  output logic [1:0]             rsp_code,
  output logic [DI_STATUS_W-1:0] rsp_xfer_status,
  output logic [DI_TERM_W-1:0]   di_term_addr,
  output logic [DI_ADDR_W-1:0]   di_reg_addr,
  output logic                   di_read_mode,
  output logic                   di_read_req,
  output logic                   di_read,
  output logic                   di_write_mode,
  output logic                   di_write,
  output logic [DI_DATA_W-1:0]   di_reg_datai,
  input  logic                   di_read_rdy,
  input  logic [DI_DATA_W-1:0]   di_reg_datao,
  input  logic                   di_write_rdy,
  input  logic [DI_STATUS_W-1:0] di_transfer_status,
  input  logic                   di_en
);

  di_state_t state, state_next;

  logic                   write_reg;
  logic                   to_clr;
  logic                   to_en;
  logic                   to_tc;
  logic                   load_rsp;
  logic [1:0]             code_next;
  logic [DI_DATA_W-1:0]   rdata_next;
  logic [DI_STATUS_W-1:0] status_next;

  di_timeout_cnt #(
    .TO_WIDTH       (TO_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (di_clk),
    .reset (reset),
    .clr   (to_clr),
    .en    (to_en),
    .tc    (to_tc)
  );

  // FSM state register.
  always_ff @(posedge di_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, bus strobes/modes and the response to load on completion.
  // The response is resolved on the edge into RESP so it is valid during RESP.
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    di_read_mode  = 1'b0;
    di_read_req   = 1'b0;
    di_read       = 1'b0;
    di_write_mode = 1'b0;
    di_write      = 1'b0;
    to_clr        = 1'b1;
    to_en         = 1'b0;
    load_rsp      = 1'b0;
    code_next     = DI_RSP_OK;
    rdata_next    = '0;
    status_next   = '0;
    case (state)
      ST_IDLE: begin
        // Held low while reset is asserted so every output reads 0.
        cmd_ready = !reset;
        if (cmd_valid && !reset) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        di_write_mode = write_reg;
        di_read_mode  = !write_reg;
        if (!di_en) begin
          load_rsp   = 1'b1;
          code_next  = DI_RSP_NO_TERM;
          state_next = ST_RESP;
        end else begin
          state_next = write_reg ? ST_WWAIT : ST_RREQ;
        end
      end
      ST_WWAIT: begin
        di_write_mode = 1'b1;
        to_clr        = 1'b0;
        if (di_write_rdy) begin
          di_write    = 1'b1;
          load_rsp    = 1'b1;
          status_next = di_transfer_status;
          code_next   = (di_transfer_status != '0) ? DI_RSP_XFER_ERR : DI_RSP_OK;
          state_next  = ST_RESP;
        end else if (to_tc) begin
          load_rsp   = 1'b1;
          code_next  = DI_RSP_TIMEOUT;
          state_next = ST_RESP;
        end else begin
          to_en = 1'b1;
        end
      end
      ST_RREQ: begin
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
        state_next   = ST_RWAIT;
      end
      ST_RWAIT: begin
        di_read_mode = 1'b1;
        to_clr       = 1'b0;
        if (di_read_rdy) begin
          di_read     = 1'b1;
          load_rsp    = 1'b1;
          rdata_next  = di_reg_datao;
          status_next = di_transfer_status;
          code_next   = (di_transfer_status != '0) ? DI_RSP_XFER_ERR : DI_RSP_OK;
          state_next  = ST_RESP;
        end else if (to_tc) begin
          load_rsp   = 1'b1;
          code_next  = DI_RSP_TIMEOUT;
          state_next = ST_RESP;
        end else begin
          to_en = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch on accept and response registers that hold until the next RESP.
  always_ff @(posedge di_clk or posedge reset) begin
    if (reset) begin
      write_reg       <= 1'b0;
      di_term_addr    <= '0;
      di_reg_addr     <= '0;
      di_reg_datai    <= '0;
      rsp_code        <= DI_RSP_OK;
      rsp_rdata       <= '0;
      rsp_xfer_status <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        write_reg    <= cmd_write;
        di_term_addr <= cmd_term;
        di_reg_addr  <= cmd_addr;
        di_reg_datai <= cmd_wdata;
      end
      if (load_rsp) begin
        rsp_code        <= code_next;
        rsp_rdata       <= rdata_next;
        rsp_xfer_status <= status_next;
      end
    end
  end

endmodule

// File: doc/di_reg_master.md
Name: di_reg_master

Overview:
- Single-outstanding DI-bus initiator.
- Turns a simple command/response interface into the DI terminal read/write handshake. It drives di_term_addr, di_reg_addr, the mode, request and strobe lines, and returns read data and status.
- Used by on-chip sequencers and benches to program terminals such as CcmTest, and is the counterpart of every terminal responder.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for di_write_rdy or di_read_rdy before aborting.
- TO_WIDTH, 11: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- di_clk  in  1  bus clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_term  in  16  terminal address
- cmd_addr  in  32  register address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse; response fields valid
- rsp_rdata  out  32  read data (0 for writes)
- rsp_code  out  2  0=OK, 1=XFER_ERR, 2=TIMEOUT, 3=NO_TERM
- rsp_xfer_status  out  16  di_transfer_status captured at completion
- di_term_addr  out  16  registered terminal address
- di_reg_addr  out  32  registered register address
- di_read_mode  out  1  high for the whole read transaction
- di_read_req  out  1  one-cycle read request pulse
- di_read  out  1  one-cycle read strobe
- di_write_mode  out  1  high for the whole write transaction
- di_write  out  1  one-cycle write strobe
- di_reg_datai  out  32  write data to the terminal
- di_read_rdy  in  1  terminal has read data
- di_reg_datao  in  32  terminal read data
- di_write_rdy  in  1  terminal can accept a write
- di_transfer_status  in  16  nonzero = terminal error
- di_en  in  1  addressed terminal exists

Behaviour:
- Reset (async): all outputs 0; state IDLE; timeout counter 0.
- States: IDLE, SETUP, WWAIT, RREQ, RWAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch term, addr, wdata, write flag into di_term_addr, di_reg_addr, di_reg_datai.
  - Assert di_write_mode or di_read_mode from the next cycle.
  - Go to SETUP.
- SETUP (1 cycle; addresses and mode stable):
  - di_en==0: rsp_code=NO_TERM, go to RESP.
  - Else go to WWAIT for a write, RREQ for a read.
- RREQ:
  - di_read_req=1 for exactly this cycle.
  - Go to RWAIT; clear the timeout counter.
- WWAIT:
  - Each cycle, if di_write_rdy: di_write=1 this cycle only; capture di_transfer_status; go to RESP.
  - Else increment the counter; at TIMEOUT_CYCLES-1 set rsp_code=TIMEOUT and go to RESP.
- RWAIT:
  - Same as WWAIT, but on di_read_rdy: di_read=1 this cycle only; capture di_reg_datao and di_transfer_status in the same cycle.
- RESP:
  - rsp_valid=1 for one cycle.
  - rsp_code=XFER_ERR if captured status is nonzero and no earlier code was set.
  - Modes drop to 0 this cycle; return to IDLE.
  - rsp fields hold until the next RESP.
- Latency with the ready input already high:
  - write: accept at cycle 0, di_write at cycle 2, rsp_valid at cycle 3.
  - read: di_read_req at cycle 2, di_read at cycle 3 at the earliest, rsp_valid at cycle 4.
- Strobes:
  - di_write and di_read are never high for more than one cycle per transaction.
  - They never coincide with a mode of the other direction.
- cmd_ready=0 outside IDLE; cmd_valid is ignored there, with no queueing.
- A new command can be accepted in the cycle after RESP, i.e. back-to-back with one idle cycle.
- di_term_addr and di_reg_addr hold their last value in IDLE; only modes and strobes return to 0.
- Timeout or NO_TERM: rsp_rdata=0; no strobe is issued.
- Reset mid-transaction: immediate abort, no response, all strobes and modes 0.

Decomposition:
- Shared package/include: state encoding, rsp_code constants (DI_RSP_OK, DI_RSP_XFER_ERR, DI_RSP_TIMEOUT, DI_RSP_NO_TERM), and DI address widths (16/32).
- Sub-module: di_timeout_cnt, a clear/enable counter with terminal-count flag, parameterised by TO_WIDTH and TIMEOUT_CYCLES.

Test Plan:
- Write term=CcmTest, addr=3, data=0x20, responder always ready with status 0 -> di_write pulses once at cycle 2 with di_reg_datai=0x20; rsp_valid at cycle 3; rsp_code=0.
- Read addr=5, responder raises di_read_rdy 4 cycles after di_read_req with datao=0xDEADBEEF -> single di_read pulse in the rdy cycle; rsp_rdata=0xDEADBEEF; rsp_code=0.
- Command to an unmapped term, di_en=0 -> no di_read_req/di_write; rsp_code=3; rsp_xfer_status=0.
- Responder returns di_transfer_status=1 on a write -> rsp_code=1; rsp_xfer_status=1.
- TIMEOUT_CYCLES=8, di_read_rdy held 0 -> rsp_code=2 exactly 8 cycles after entering RWAIT; no di_read pulse; modes low after RESP.
- Assert reset 1 cycle into WWAIT, then issue a back-to-back write and read -> outputs 0 immediately, no rsp_valid; both later commands complete in order, and cmd_ready is low throughout each transaction.
